// File: rtl/fpu_req_ctrl.sv
// Request controller sitting between a valid/ready command stream and a fixed-latency FPU.
// One operation in flight; the result is held until the downstream handshake completes.
module fpu_req_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int FPU_LAT    = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [3:0]            cmd_op_i,
  input  logic [DATA_WIDTH-1:0] cmd_a_i,
  input  logic [DATA_WIDTH-1:0] cmd_b_i,
  output logic [3:0]            fpu_op_o,
  output logic [DATA_WIDTH-1:0] fpu_in1_o,
  output logic [DATA_WIDTH-1:0] fpu_in2_o,
  input  logic [DATA_WIDTH-1:0] fpu_out_i,
  input  logic                  fpu_overflow_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_data_o,
  output logic                  rsp_overflow_o,
  output logic                  sticky_ovf_o,
  input  logic                  sticky_clr_i,
  output logic [15:0]           op_cnt_o
);

  localparam int CW = (FPU_LAT > 0) ? $clog2(FPU_LAT + 1) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                  state_q;
  logic [CW-1:0]           wait_q;
  logic [3:0]              op_q;
  logic [DATA_WIDTH-1:0]   in1_q;
  logic [DATA_WIDTH-1:0]   in2_q;
  logic [DATA_WIDTH-1:0]   rsp_data_q;
  logic                    rsp_ovf_q;
  logic                    sticky_q;
  logic [15:0]             op_cnt_q;
  logic                    capture;

  assign capture = (state_q == BUSY) && (wait_q == '0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      op_q       <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      rsp_data_q <= '0;
      rsp_ovf_q  <= 1'b0;
      sticky_q   <= 1'b0;
      op_cnt_q   <= '0;
    end else begin
      // Counter is rewritten every cycle; it simply adds the capture strobe.
      op_cnt_q <= op_cnt_q + {15'd0, capture};

      if (capture && fpu_overflow_i) begin
        sticky_q <= 1'b1;
      end else if (sticky_clr_i) begin
        sticky_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (cmd_valid_i) begin
            op_q    <= cmd_op_i;
            in1_q   <= cmd_a_i;
            in2_q   <= cmd_b_i;
            wait_q  <= CW'(FPU_LAT);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (wait_q != '0) begin
            wait_q <= wait_q - CW'(1);
          end else begin
            rsp_data_q <= fpu_out_i;
            rsp_ovf_q  <= fpu_overflow_i;
            state_q    <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready_i) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o    = (state_q == IDLE);
  assign rsp_valid_o    = (state_q == RESP);
  assign fpu_op_o       = op_q;
  assign fpu_in1_o      = in1_q;
  assign fpu_in2_o      = in2_q;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_overflow_o = rsp_ovf_q;
  assign sticky_ovf_o   = sticky_q;
  assign op_cnt_o       = op_cnt_q;

endmodule

// File: tb/tb_fpu_req_ctrl.sv
// Bench for fpu_req_ctrl: one instance with a combinational FPU (lat 0), one with lat 3.
module tb_fpu_req_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  cmd_op = '0;
  logic [15:0] cmd_a = '0;
  logic [15:0] cmd_b = '0;

  logic        c0_vld = 0, c0_rdy, r0_vld, r0_rdy = 0, r0_ovf, s0, s0_clr = 0, f0_ovf = 0;
  logic [3:0]  f0_op;
  logic [15:0] f0_in1, f0_in2, f0_out = '0, r0_dat, cnt0;

  logic        c3_vld = 0, c3_rdy, r3_vld, r3_rdy = 0, r3_ovf, s3, s3_clr = 0, f3_ovf = 0;
  logic [3:0]  f3_op;
  logic [15:0] f3_in1, f3_in2, f3_out = '0, r3_dat, cnt3;

  typedef struct packed {
    logic [15:0] dat;
    logic        ovf;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  exp_t e;
  int   total = 0;
  int   bad = 0;
  logic [15:0] exp_cnt0 = '0;
  logic [15:0] exp_cnt3 = '0;

  always #5 clk = ~clk;

  fpu_req_ctrl #(.DATA_WIDTH(16), .FPU_LAT(0)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(c0_vld), .cmd_ready_o(c0_rdy),
    .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .fpu_op_o(f0_op), .fpu_in1_o(f0_in1), .fpu_in2_o(f0_in2),
    .fpu_out_i(f0_out), .fpu_overflow_i(f0_ovf),
    .rsp_valid_o(r0_vld), .rsp_ready_i(r0_rdy),
    .rsp_data_o(r0_dat), .rsp_overflow_o(r0_ovf),
    .sticky_ovf_o(s0), .sticky_clr_i(s0_clr), .op_cnt_o(cnt0)
  );

  fpu_req_ctrl #(.DATA_WIDTH(16), .FPU_LAT(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst),
    .cmd_valid_i(c3_vld), .cmd_ready_o(c3_rdy),
    .cmd_op_i(cmd_op), .cmd_a_i(cmd_a), .cmd_b_i(cmd_b),
    .fpu_op_o(f3_op), .fpu_in1_o(f3_in1), .fpu_in2_o(f3_in2),
    .fpu_out_i(f3_out), .fpu_overflow_i(f3_ovf),
    .rsp_valid_o(r3_vld), .rsp_ready_i(r3_rdy),
    .rsp_data_o(r3_dat), .rsp_overflow_o(r3_ovf),
    .sticky_ovf_o(s3), .sticky_clr_i(s3_clr), .op_cnt_o(cnt3)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one command into the lat-0 instance (which must be idle) and records its stub result.
  task automatic issue0(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] res, input logic ovf);
    cmd_op = op; cmd_a = a; cmd_b = b;
    f0_out = res; f0_ovf = ovf;
    c0_vld = 1'b1;
    q0.push_back({res, ovf});
    tick();
    c0_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    total++; if (c0_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy0: got %b want 1", c0_rdy); end
    total++; if (c3_rdy !== 1'b1) begin bad++; $display("FAIL reset_rdy3: got %b want 1", c3_rdy); end
    total++; if ({r0_vld, r0_ovf, s0, r0_dat, f0_in1, f0_in2, f0_op, cnt0} !== '0) begin
      bad++; $display("FAIL reset_outs0: vld=%b ovf=%b st=%b dat=%h in1=%h in2=%h op=%h cnt=%h want all 0",
                      r0_vld, r0_ovf, s0, r0_dat, f0_in1, f0_in2, f0_op, cnt0);
    end
    total++; if ({r3_vld, r3_ovf, s3, r3_dat, cnt3} !== '0) begin
      bad++; $display("FAIL reset_outs3: vld=%b ovf=%b st=%b dat=%h cnt=%h want all 0", r3_vld, r3_ovf, s3, r3_dat, cnt3);
    end
  endtask

  task automatic test_basic();
    issue0(4'h0, 16'h3F80, 16'h4000, 16'h4040, 1'b0);
    total++; if ({f0_op, f0_in1, f0_in2} !== {4'h0, 16'h3F80, 16'h4000}) begin
      bad++; $display("FAIL basic_drive: op=%h in1=%h in2=%h want 0 3f80 4000", f0_op, f0_in1, f0_in2);
    end
    total++; if ({c0_rdy, r0_vld} !== 2'b00) begin bad++; $display("FAIL basic_busy: rdy=%b vld=%b want 0 0", c0_rdy, r0_vld); end
    tick();
    e = q0.pop_front();
    exp_cnt0++;
    total++; if (r0_vld !== 1'b1) begin bad++; $display("FAIL basic_vld: got %b want 1", r0_vld); end
    total++; if ({r0_dat, r0_ovf} !== {e.dat, e.ovf}) begin
      bad++; $display("FAIL basic_data: got %h/%b want %h/%b", r0_dat, r0_ovf, e.dat, e.ovf);
    end
    total++; if (cnt0 !== exp_cnt0) begin bad++; $display("FAIL basic_cnt: got %h want %h", cnt0, exp_cnt0); end
    r0_rdy = 1'b1;
    tick();
    r0_rdy = 1'b0;
    total++; if ({r0_vld, c0_rdy} !== 2'b01) begin bad++; $display("FAIL basic_done: vld=%b rdy=%b want 0 1", r0_vld, c0_rdy); end
  endtask

  task automatic test_backpressure();
    logic ok = 1'b1;
    issue0(4'h3, 16'h4120, 16'hC000, 16'h1234, 1'b0);
    tick();
    e = q0.pop_front();
    exp_cnt0++;
    for (int i = 0; i < 5; i++) begin
      // Upstream keeps offering a different command and the FPU output wanders; both must be ignored.
      c0_vld = 1'b1; cmd_a = 16'hAAAA; cmd_b = 16'h5555;
      f0_out = 16'($urandom); f0_ovf = 1'b1;
      tick();
      if ({r0_vld, c0_rdy, r0_dat, r0_ovf, f0_in1, f0_in2} !== {1'b1, 1'b0, e.dat, e.ovf, 16'h4120, 16'hC000}) ok = 1'b0;
    end
    c0_vld = 1'b0; f0_ovf = 1'b0;
    total++; if (ok !== 1'b1) begin
      bad++; $display("FAIL bp_hold: vld=%b rdy=%b dat=%h in1=%h want 1 0 %h 4120", r0_vld, c0_rdy, r0_dat, f0_in1, e.dat);
    end
    total++; if (cnt0 !== exp_cnt0) begin bad++; $display("FAIL bp_cnt: got %h want %h", cnt0, exp_cnt0); end
    r0_rdy = 1'b1;
    tick();
    r0_rdy = 1'b0;
    total++; if ({r0_vld, c0_rdy} !== 2'b01) begin bad++; $display("FAIL bp_release: vld=%b rdy=%b want 0 1", r0_vld, c0_rdy); end
  endtask

  task automatic test_idle();
    logic ok = 1'b1;
    r0_rdy = 1'b1; c0_vld = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if ({c0_rdy, r0_vld, cnt0} !== {1'b1, 1'b0, exp_cnt0}) ok = 1'b0;
    end
    r0_rdy = 1'b0;
    total++; if (ok !== 1'b1) begin
      bad++; $display("FAIL idle_hold: rdy=%b vld=%b cnt=%h want 1 0 %h", c0_rdy, r0_vld, cnt0, exp_cnt0);
    end
  endtask

  task automatic test_back_to_back();
    int errs = 0;
    logic [15:0] a, b;
    r0_rdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      issue0(4'(i), a, b, a ^ b, 1'b0);
      tick();
      e = q0.pop_front();
      exp_cnt0++;
      if ({r0_vld, r0_dat, r0_ovf, cnt0} !== {1'b1, e.dat, e.ovf, exp_cnt0}) begin
        errs++; $display("FAIL b2b_rsp%0d: vld=%b dat=%h cnt=%h want 1 %h %h", i, r0_vld, r0_dat, cnt0, e.dat, exp_cnt0);
      end
      tick();
      if (c0_rdy !== 1'b1) begin errs++; $display("FAIL b2b_rdy%0d: got %b want 1", i, c0_rdy); end
    end
    r0_rdy = 1'b0;
    total++; if (errs != 0) bad++;
  endtask

  task automatic test_overflow();
    issue0(4'h1, 16'h7F00, 16'h7F00, 16'h7F80, 1'b1);
    tick();
    e = q0.pop_front(); exp_cnt0++;
    total++; if ({r0_dat, r0_ovf, s0} !== {e.dat, e.ovf, 1'b1}) begin
      bad++; $display("FAIL ovf_first: dat=%h ovf=%b st=%b want %h %b 1", r0_dat, r0_ovf, s0, e.dat, e.ovf);
    end
    r0_rdy = 1'b1; tick(); r0_rdy = 1'b0;
    issue0(4'h1, 16'h3F80, 16'h0000, 16'h3F80, 1'b0);
    tick();
    e = q0.pop_front(); exp_cnt0++;
    total++; if ({r0_dat, r0_ovf, s0} !== {e.dat, e.ovf, 1'b1}) begin
      bad++; $display("FAIL ovf_keep: dat=%h ovf=%b st=%b want %h %b 1", r0_dat, r0_ovf, s0, e.dat, e.ovf);
    end
    r0_rdy = 1'b1; tick(); r0_rdy = 1'b0;
    s0_clr = 1'b1; tick(); s0_clr = 1'b0;
    total++; if (s0 !== 1'b0) begin bad++; $display("FAIL ovf_clear: st=%b want 0", s0); end
    issue0(4'h2, 16'h7F7F, 16'h7F7F, 16'h7F80, 1'b1);
    s0_clr = 1'b1;
    tick();
    s0_clr = 1'b0;
    e = q0.pop_front(); exp_cnt0++;
    total++; if ({r0_ovf, s0, cnt0} !== {1'b1, 1'b1, exp_cnt0}) begin
      bad++; $display("FAIL ovf_set_wins: ovf=%b st=%b cnt=%h want 1 1 %h", r0_ovf, s0, cnt0, exp_cnt0);
    end
    r0_rdy = 1'b1; tick(); r0_rdy = 1'b0;
  endtask

  task automatic test_lat3();
    logic ok = 1'b1;
    cmd_op = 4'h5; cmd_a = 16'h4080; cmd_b = 16'h4100;
    f3_out = 16'h1111; f3_ovf = 1'b0;
    c3_vld = 1'b1;
    tick();
    c3_vld = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      if ({r3_vld, c3_rdy, f3_op, f3_in1, f3_in2} !== {1'b0, 1'b0, 4'h5, 16'h4080, 16'h4100}) ok = 1'b0;
      f3_out = 16'hDEA0 + 16'(i); f3_ovf = 1'b1;
      tick();
    end
    total++; if (ok !== 1'b1) begin
      bad++; $display("FAIL lat3_busy: vld=%b rdy=%b in1=%h in2=%h want 0 0 4080 4100", r3_vld, c3_rdy, f3_in1, f3_in2);
    end
    total++; if (r3_vld !== 1'b0) begin bad++; $display("FAIL lat3_early: vld=%b want 0 before capture edge", r3_vld); end
    f3_out = 16'h4240; f3_ovf = 1'b0;
    q3.push_back({16'h4240, 1'b0});
    tick();
    f3_out = 16'hBEEF;
    e = q3.pop_front(); exp_cnt3++;
    total++; if ({r3_vld, r3_dat, r3_ovf, cnt3} !== {1'b1, e.dat, e.ovf, exp_cnt3}) begin
      bad++; $display("FAIL lat3_capture: vld=%b dat=%h ovf=%b cnt=%h want 1 %h %b %h", r3_vld, r3_dat, r3_ovf, cnt3, e.dat, e.ovf, exp_cnt3);
    end
    r3_rdy = 1'b1; tick(); r3_rdy = 1'b0;
    total++; if ({r3_vld, c3_rdy} !== 2'b01) begin bad++; $display("FAIL lat3_done: vld=%b rdy=%b want 0 1", r3_vld, c3_rdy); end
  endtask

  task automatic test_reset_mid();
    logic ok = 1'b1;
    cmd_op = 4'h7; cmd_a = 16'h3F00; cmd_b = 16'h3E00;
    f0_out = 16'h5555; f0_ovf = 1'b1; f3_out = 16'h6666; f3_ovf = 1'b1;
    c0_vld = 1'b1; c3_vld = 1'b1;
    tick();
    c0_vld = 1'b0; c3_vld = 1'b0;
    tick();
    total++; if ({r0_vld, r3_vld} !== 2'b10) begin bad++; $display("FAIL rstmid_pre: vld0=%b vld3=%b want 1 0", r0_vld, r3_vld); end
    // Reset must beat a simultaneous command offer and sticky clear.
    rst = 1'b1; c0_vld = 1'b1; c3_vld = 1'b1; s0_clr = 1'b1; cmd_a = 16'hAAAA;
    tick();
    rst = 1'b0; c0_vld = 1'b0; c3_vld = 1'b0; s0_clr = 1'b0;
    f0_ovf = 1'b0; f3_ovf = 1'b0;
    q0.delete(); q3.delete(); exp_cnt0 = '0; exp_cnt3 = '0;
    total++; if ({r0_vld, s0, cnt0, f0_in1, c0_rdy} !== {1'b0, 1'b0, 16'h0, 16'h0, 1'b1}) begin
      bad++; $display("FAIL rstmid_d0: vld=%b st=%b cnt=%h in1=%h rdy=%b want 0 0 0 0 1", r0_vld, s0, cnt0, f0_in1, c0_rdy);
    end
    total++; if ({r3_vld, cnt3, f3_in1, c3_rdy} !== {1'b0, 16'h0, 16'h0, 1'b1}) begin
      bad++; $display("FAIL rstmid_d3: vld=%b cnt=%h in1=%h rdy=%b want 0 0 0 1", r3_vld, cnt3, f3_in1, c3_rdy);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      if ({r0_vld, r3_vld, cnt0, cnt3} !== '0) ok = 1'b0;
    end
    total++; if (ok !== 1'b1) begin
      bad++; $display("FAIL rstmid_quiet: vld0=%b vld3=%b cnt0=%h cnt3=%h want all 0", r0_vld, r3_vld, cnt0, cnt3);
    end
  endtask

  task automatic test_wrap();
    int errs = 0;
    // Preload the completion counter just below wrap rather than running 65534 operations.
    force u_dut0.op_cnt_q = 16'hFFFE;
    tick();
    release u_dut0.op_cnt_q;
    exp_cnt0 = 16'hFFFE;
    total++; if (cnt0 !== exp_cnt0) begin bad++; $display("FAIL wrap_preload: got %h want %h", cnt0, exp_cnt0); end
    r0_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue0(4'h0, 16'(i), 16'h0001, 16'h0100 + 16'(i), 1'b0);
      tick();
      e = q0.pop_front();
      exp_cnt0++;
      if ({r0_dat, cnt0} !== {e.dat, exp_cnt0}) begin
        errs++; $display("FAIL wrap_op%0d: dat=%h cnt=%h want %h %h", i, r0_dat, cnt0, e.dat, exp_cnt0);
      end
      tick();
    end
    r0_rdy = 1'b0;
    total++; if (errs != 0) bad++;
    total++; if (cnt0 !== 16'h0001) begin bad++; $display("FAIL wrap_final: got %h want 0001", cnt0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_idle();
    test_back_to_back();
    test_overflow();
    test_lat3();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fpu_req_ctrl.md
FPU_REQ_CTRL -- requirements
Module: fpu_req_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, operand/result width (bfloat16).
REQ-002 SHALL have parameter FPU_LAT, default 0, cycles from drive-register update to valid fpu_out_i (0 = combinational FPU).
REQ-003 SHALL have port clk_i  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port cmd_valid_i  input  1  upstream command valid.
REQ-006 SHALL have port cmd_ready_o  output  1  command accepted when cmd_valid_i & cmd_ready_o.
REQ-007 SHALL have port cmd_op_i  input  4  opcode, passed to FPU unmodified.
REQ-008 SHALL have port cmd_a_i  input  DATA_WIDTH  operand 1.
REQ-009 SHALL have port cmd_b_i  input  DATA_WIDTH  operand 2.
REQ-010 SHALL have port fpu_op_o  output  4  registered opcode driven to FPU op_i.
REQ-011 SHALL have port fpu_in1_o  output  DATA_WIDTH  registered operand to FPU in1_i.
REQ-012 SHALL have port fpu_in2_o  output  DATA_WIDTH  registered operand to FPU in2_i.
REQ-013 SHALL have port fpu_out_i  input  DATA_WIDTH  FPU result.
REQ-014 SHALL have port fpu_overflow_i  input  1  FPU overflow flag.
REQ-015 SHALL have port rsp_valid_o  output  1  response valid.
REQ-016 SHALL have port rsp_ready_i  input  1  downstream ready.
REQ-017 SHALL have port rsp_data_o  output  DATA_WIDTH  captured result.
REQ-018 SHALL have port rsp_overflow_o  output  1  captured overflow for this response.
REQ-019 SHALL have port sticky_ovf_o  output  1  OR of all captured overflows since reset/clear.
REQ-020 SHALL have port sticky_clr_i  input  1  clears sticky_ovf_o.
REQ-021 SHALL have port op_cnt_o  output  16  count of completed (captured) operations.

Function
REQ-022 SHALL implement FSM states IDLE, BUSY, RESP; all outputs registered or decoded from state only.
REQ-023 SHALL drive cmd_ready_o = 1 only in IDLE; rsp_valid_o = 1 only in RESP.
REQ-024 On accept in IDLE: load fpu_op_o/fpu_in1_o/fpu_in2_o from cmd_*, load wait counter with FPU_LAT, go BUSY.
REQ-025 In BUSY with counter != 0: decrement; with counter == 0: capture fpu_out_i -> rsp_data_o, fpu_overflow_i -> rsp_overflow_o, go RESP.
REQ-026 Latency: accept at edge N -> rsp_valid_o high after edge N+1+FPU_LAT (BUSY lasts FPU_LAT+1 cycles).
REQ-027 In RESP: hold rsp_data_o/rsp_overflow_o stable while rsp_ready_i = 0; on rsp_ready_i = 1 go IDLE at that edge.
REQ-028 Throughput: max one op per FPU_LAT+3 cycles; no new accept until response handshake completes.
REQ-029 fpu_* drive registers SHALL change only on accept; they hold the last command in IDLE/RESP.
REQ-030 cmd_* inputs SHALL be ignored outside IDLE; cmd_valid_i low in IDLE keeps IDLE.
REQ-031 sticky_ovf_o set on capture with fpu_overflow_i = 1; cleared by sticky_clr_i; set wins over simultaneous clear.
REQ-032 op_cnt_o increments by 1 on each capture; wraps 0xFFFF -> 0x0000 silently.
REQ-033 rsp_valid_o SHALL not drop before handshake; rsp_ready_i high outside RESP has no effect.

Reset
REQ-034 rst_i high at edge: state IDLE, all outputs 0 (cmd_ready_o = 1 from the first cycle after reset releases), counters 0, sticky 0.
REQ-035 Reset mid-BUSY or mid-RESP SHALL abandon the operation: no response issued, op_cnt_o not incremented.
REQ-036 rst_i has priority over every other input, including cmd_valid_i and sticky_clr_i in the same cycle.

Verification
REQ-037 FPU_LAT=0, stub FPU returns 0x4040: accept op=4'h0, a=0x3F80, b=0x4000 at edge N -> fpu_in1_o=0x3F80, fpu_in2_o=0x4000 after N; rsp_valid_o=1, rsp_data_o=0x4040 after N+1; op_cnt_o=1.
REQ-038 Backpressure: rsp_ready_i=0 for 5 cycles in RESP -> rsp_valid_o and rsp_data_o stable, cmd_ready_o=0; rsp_ready_i=1 -> IDLE next cycle.
REQ-039 FPU_LAT=3: accept at edge N -> capture at edge N+4, rsp_valid_o high after N+4; fpu_out_i changes before N+4 are not captured.
REQ-040 Overflow: stub asserts fpu_overflow_i=1 with result 0x7F80 -> rsp_overflow_o=1, sticky_ovf_o=1; next op overflow=0 keeps sticky=1; sticky_clr_i coincident with an overflowing capture leaves sticky=1.
REQ-041 Reset in BUSY -> IDLE, rsp_valid_o never asserted, op_cnt_o=0; 65536 completed ops -> op_cnt_o=0x0000.
